// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: a multiply leaves RUN once the remaining multiplier is zero.
module mdu_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned PW = 2 * XLEN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    logic [1:0]      state, state_nx;
    logic            div_q, sa, sb;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   prod, mcand;
    logic [XLEN-1:0] mplier, quot, dvs, a_raw;
    logic [XLEN:0]   rem;

    logic            issue, last_step, q_bit, s_a, s_b, neg;
    logic [XLEN-1:0] a_mag, b_mag, mplier_nx;
    logic [XLEN:0]   rem_sh, rem_dif;
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] hi_res, lo_res;

    // Next-state, operand conditioning, datapath step and sign fixup
    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        s_a       = ~op[0] & a[XLEN-1];
        s_b       = ~op[0] & b[XLEN-1];
        a_mag     = s_a ? (~a + XLEN'(1)) : a;
        b_mag     = s_b ? (~b + XLEN'(1)) : b;
        mplier_nx = mplier >> 1;
        rem_sh    = (XLEN+1)'({rem, quot[XLEN-1]});
        rem_dif   = rem_sh - {1'b0, dvs};
        q_bit     = (rem_sh >= {1'b0, dvs});
        last_step = (cnt == CW'(1));
`ifdef MDU_EARLY_OUT_EN
        if (!div_q && (mplier_nx == '0)) begin
            last_step = 1'b1;
        end
`endif
        neg       = sa ^ sb;
        prod_fix  = neg ? (~prod + PW'(1)) : prod;
        hi_res    = prod_fix[PW-1:XLEN];
        lo_res    = prod_fix[XLEN-1:0];
        if (div_q) begin
            if (dvs == '0) begin
                hi_res = a_raw;
                lo_res = '1;
            end else begin
                hi_res = sa  ? (~rem[XLEN-1:0] + XLEN'(1)) : rem[XLEN-1:0];
                lo_res = neg ? (~quot + XLEN'(1)) : quot;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    issue    = ~flush;
                end
            end
            S_RUN:   if (last_step) state_nx = S_FIXUP;
            S_FIXUP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand latch, shift-add / restoring-divide step, HI/LO update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            div_q  <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            quot   <= '0;
            dvs    <= '0;
            a_raw  <= '0;
            rem    <= '0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state == S_FIXUP) && !flush;

            if (state == S_IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end else if ((state == S_FIXUP) && !flush) begin
                hi <= hi_res;
                lo <= lo_res;
            end

            if (issue) begin
                div_q  <= op[1];
                sa     <= s_a;
                sb     <= s_b;
                cnt    <= CW'(XLEN);
                prod   <= '0;
                mcand  <= {XLEN'(0), a_mag};
                mplier <= b_mag;
                quot   <= a_mag;
                dvs    <= b_mag;
                a_raw  <= a;
                rem    <= '0;
            end else if (state == S_RUN) begin
                cnt <= cnt - CW'(1);
                if (!div_q) begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nx;
                end else begin
                    rem  <= q_bit ? rem_dif : rem_sh;
                    quot <= {quot[XLEN-2:0], q_bit};
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: randomized and directed ops against an arithmetic reference model.
module tb_mdu_iter;

    localparam int unsigned XLEN = 32;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op    = 2'd0;
    logic [XLEN-1:0] a     = '0;
    logic [XLEN-1:0] b     = '0;
    logic            flush = 1'b0;
    logic            hi_we = 1'b0;
    logic            lo_we = 1'b0;
    logic [XLEN-1:0] wdata = '0;
    logic            busy, done;
    logic [XLEN-1:0] hi, lo;

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] m;
        int          bl;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'(0);
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
        endcase
        e.hi  = p[63:32];
        e.lo  = p[31:0];
        e.lat = XLEN + 1;
        e.cyc = 0;
`ifdef MDU_EARLY_OUT_EN
        if (o[1] == 1'b0) begin
            m  = (o == 2'd0 && y[31]) ? (32'd0 - y) : y;
            bl = 0;
            for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
            e.lat = ((bl < 1) ? 1 : bl) + 1;
        end
`else
        m  = y;
        bl = 0;
`endif
        return e;
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb_q.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("latency", 64'(cyc - e.cyc), 64'(e.lat));
                check("busy_cycles", 64'(busy_cycles), 64'(e.lat));
            end
            busy_cycles = 0;
        end else if (busy) begin
            busy_cycles++;
        end else begin
            busy_cycles = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_timeout", 64'(done), 64'(1));
    endtask

    task automatic drive_raw(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    // Issue now (caller is at a negedge with busy low); MT writes on the issue edge get overwritten
    task automatic issue_now(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                             input bit use_c, input logic [31:0] hc, input logic [31:0] lc);
        exp_t e;
        e = model(o, x, y);
        if (use_c) begin
            e.hi = hc;
            e.lo = lc;
        end
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom;
        drive_raw(o, x, y);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit use_c, input logic [31:0] hc, input logic [31:0] lc);
        wait_idle();
        issue_now(o, x, y, use_c, hc, lc);
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        wait_idle();
        hi_we = 1'b1;
        wdata = h;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = l;
        @(negedge clk);
        lo_we = 1'b0;
        check("preload_hi", 64'(hi), 64'(h));
        check("preload_lo", 64'(lo), 64'(l));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        rst = 1'b1;

        // MULT -3 * 7, with an ignored start while busy
        issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;

        // MULTU issued in the done cycle of the previous op
        wait_done();
        check("b2b_busy", 64'(busy), 64'(0));
        issue_now(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);

        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        issue(2'd3, 32'd5, 32'd0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF);
        issue(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
`ifdef MDU_EARLY_OUT_EN
        issue(2'd1, 32'd5, 32'd3, 1'b1, 32'h0000_0000, 32'h0000_000F);
`endif

        // Flush mid-operation: no done, HI/LO untouched, MT write while busy ignored
        preload(32'h1111, 32'h2222);
        drive_raw(2'd0, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        hi_we = 1'b1; wdata = 32'h9999;
        @(negedge clk);
        hi_we = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        repeat (40) @(negedge clk);
        check("flush_hi", 64'(hi), 64'(32'h1111));
        check("flush_lo", 64'(lo), 64'(32'h2222));

        // Start on the same edge as flush is dropped
        flush = 1'b1;
        drive_raw(2'd0, 32'd3, 32'd4);
        flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'(0));

        // Async reset mid-operation
        drive_raw(2'd0, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'b0, 32'd0, 32'd0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
